// File: rtl/writeback_store_stage.sv
// Final pipeline stage: commits register results and performs stores through a dCache handshake.
// Optional retirement counter (retiredCountOut) is built when WB_RETIRE_COUNT_EN is defined.
module writeback_store_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic [7:0]        opcodeIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [DATA_W-1:0] destRegValueIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [ADDR_W-1:0] memoryAddressDestIn,
  input  logic [DATA_W-1:0] storeDataIn,
  output logic              wbStallOut,
  output logic              regWrEnOut,
  output logic [REG_W-1:0]  regWrIdxOut,
  output logic [DATA_W-1:0] regWrDataOut,
  output logic              reqcyc,
  output logic [ADDR_W-1:0] req,
  output logic [DATA_W-1:0] reqdata,
  output logic [9:0]        reqtag,
  input  logic              reqack,
  input  logic              respcyc,
  output logic              respack
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]       retiredCountOut
`endif
);

  // state | meaning
  // IDLE  | ready to accept; non-stores retire from here
  // REQ   | store request presented, waiting for reqack
  // RESP  | request accepted, waiting for respcyc
  // ACK   | one-cycle respack, deferred register write of the store
  typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;

  state_t            state;
  logic              pendRegValid;
  logic [REG_W-1:0]  pendRegIdx;
  logic [DATA_W-1:0] pendRegData;

  assign wbStallOut = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      regWrEnOut   <= 1'b0;
      regWrIdxOut  <= '0;
      regWrDataOut <= '0;
      reqcyc       <= 1'b0;
      req          <= '0;
      reqdata      <= '0;
      reqtag       <= '0;
      respack      <= 1'b0;
      pendRegValid <= 1'b0;
      pendRegIdx   <= '0;
      pendRegData  <= '0;
`ifdef WB_RETIRE_COUNT_EN
      retiredCountOut <= '0;
`endif
    end else begin
      regWrEnOut <= 1'b0;
      respack    <= 1'b0;
      case (state)
        IDLE: begin
          if (validIn) begin
            if (isMemoryAccessDestIn) begin
              // register result is held back until the store completes
              state        <= REQ;
              reqcyc       <= 1'b1;
              req          <= memoryAddressDestIn;
              reqdata      <= storeDataIn;
              reqtag       <= {2'b11, opcodeIn};
              pendRegValid <= destRegValidIn;
              pendRegIdx   <= destRegIn;
              pendRegData  <= destRegValueIn;
            end else begin
              regWrEnOut <= destRegValidIn;
              if (destRegValidIn) begin
                regWrIdxOut  <= destRegIn;
                regWrDataOut <= destRegValueIn;
              end
`ifdef WB_RETIRE_COUNT_EN
              retiredCountOut <= retiredCountOut + 64'd1;
`endif
            end
          end
        end
        REQ: begin
          if (reqack) begin
            reqcyc <= 1'b0;
            if (respcyc) begin
              state      <= ACK;
              respack    <= 1'b1;
              regWrEnOut <= pendRegValid;
              if (pendRegValid) begin
                regWrIdxOut  <= pendRegIdx;
                regWrDataOut <= pendRegData;
              end
`ifdef WB_RETIRE_COUNT_EN
              retiredCountOut <= retiredCountOut + 64'd1;
`endif
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (respcyc) begin
            state      <= ACK;
            respack    <= 1'b1;
            regWrEnOut <= pendRegValid;
            if (pendRegValid) begin
              regWrIdxOut  <= pendRegIdx;
              regWrDataOut <= pendRegData;
            end
`ifdef WB_RETIRE_COUNT_EN
            retiredCountOut <= retiredCountOut + 64'd1;
`endif
          end
        end
        ACK: begin
          state        <= IDLE;
          pendRegValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_store_stage.sv
// Bench for writeback_store_stage: vector tables, directed corner sequences and random transactions.
module tb_writeback_store_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        validIn;
  logic [7:0]  opcodeIn;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic [63:0] destRegValueIn;
  logic        isMemoryAccessDestIn;
  logic [63:0] memoryAddressDestIn;
  logic [63:0] storeDataIn;
  logic        wbStallOut;
  logic        regWrEnOut;
  logic [3:0]  regWrIdxOut;
  logic [63:0] regWrDataOut;
  logic        reqcyc;
  logic [63:0] req;
  logic [63:0] reqdata;
  logic [9:0]  reqtag;
  logic        reqack;
  logic        respcyc;
  logic        respack;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retiredCountOut;
`endif

  writeback_store_stage #(.ADDR_W(64), .DATA_W(64), .REG_W(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef WB_RETIRE_COUNT_EN
    .retiredCountOut(retiredCountOut),
`endif
    .validIn(validIn),
    .opcodeIn(opcodeIn),
    .destRegIn(destRegIn),
    .destRegValidIn(destRegValidIn),
    .destRegValueIn(destRegValueIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn),
    .memoryAddressDestIn(memoryAddressDestIn),
    .storeDataIn(storeDataIn),
    .wbStallOut(wbStallOut),
    .regWrEnOut(regWrEnOut),
    .regWrIdxOut(regWrIdxOut),
    .regWrDataOut(regWrDataOut),
    .reqcyc(reqcyc),
    .req(req),
    .reqdata(reqdata),
    .reqtag(reqtag),
    .reqack(reqack),
    .respcyc(respcyc),
    .respack(respack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic        dv;
    logic [63:0] val;
    logic        expEn;
  } nsVec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  opc;
    logic        hasReg;
    logic [3:0]  idx;
    logic [63:0] val;
    logic [9:0]  expTag;
    int          ackDly;
    int          respDly;
    logic        hold;
    logic [3:0]  hIdx;
    logic [63:0] hVal;
  } stVec_t;

  int vecs = 0;
  int miscompares = 0;
  longint unsigned expRetired = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkRetired(input string name);
`ifdef WB_RETIRE_COUNT_EN
    chk(name, retiredCountOut, 64'(expRetired));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nonStore(input nsVec_t v);
    validIn              = 1'b1;
    isMemoryAccessDestIn = 1'b0;
    destRegIn            = v.idx;
    destRegValidIn       = v.dv;
    destRegValueIn       = v.val;
    opcodeIn             = 8'($urandom);
    memoryAddressDestIn  = {$urandom, $urandom};
    storeDataIn          = {$urandom, $urandom};
    tick();
    expRetired++;
    chk("ns_wren", 64'(regWrEnOut), 64'(v.expEn));
    if (v.expEn) begin
      chk("ns_idx", 64'(regWrIdxOut), 64'(v.idx));
      chk("ns_data", regWrDataOut, v.val);
    end
    chk("ns_stall", 64'(wbStallOut), 64'd0);
    chk("ns_reqcyc", 64'(reqcyc), 64'd0);
    chkRetired("ns_retired");
  endtask

  task automatic store(input stVec_t s);
    validIn              = 1'b1;
    isMemoryAccessDestIn = 1'b1;
    memoryAddressDestIn  = s.addr;
    storeDataIn          = s.data;
    opcodeIn             = s.opc;
    destRegValidIn       = s.hasReg;
    destRegIn            = s.idx;
    destRegValueIn       = s.val;
    tick();
    // upstream moves on; the stage must keep its latched request fields
    memoryAddressDestIn  = ~s.addr;
    storeDataIn          = ~s.data;
    opcodeIn             = ~s.opc;
    isMemoryAccessDestIn = 1'b0;
    destRegIn            = s.hIdx;
    destRegValidIn       = 1'b1;
    destRegValueIn       = s.hVal;
    validIn              = s.hold;
    for (int c = 0; c <= s.ackDly; c++) begin
      chk("req_cyc", 64'(reqcyc), 64'd1);
      chk("req_addr", req, s.addr);
      chk("req_data", reqdata, s.data);
      chk("req_tag", 64'(reqtag), 64'(s.expTag));
      chk("req_stall", 64'(wbStallOut), 64'd1);
      chk("req_wren", 64'(regWrEnOut), 64'd0);
      chk("req_respack", 64'(respack), 64'd0);
      reqack  = (c == s.ackDly);
      respcyc = (c == s.ackDly) && (s.respDly == 0);
      tick();
    end
    reqack = 1'b0;
    for (int c = 1; c <= s.respDly; c++) begin
      chk("resp_reqcyc", 64'(reqcyc), 64'd0);
      chk("resp_stall", 64'(wbStallOut), 64'd1);
      chk("resp_respack", 64'(respack), 64'd0);
      chk("resp_wren", 64'(regWrEnOut), 64'd0);
      respcyc = (c == s.respDly);
      tick();
    end
    respcyc = 1'b0;
    expRetired++;
    chk("ack_respack", 64'(respack), 64'd1);
    chk("ack_reqcyc", 64'(reqcyc), 64'd0);
    chk("ack_stall", 64'(wbStallOut), 64'd1);
    chk("ack_wren", 64'(regWrEnOut), 64'(s.hasReg));
    if (s.hasReg) begin
      chk("ack_idx", 64'(regWrIdxOut), 64'(s.idx));
      chk("ack_data", regWrDataOut, s.val);
    end
    chkRetired("ack_retired");
    tick();
    chk("idle_stall", 64'(wbStallOut), 64'd0);
    chk("idle_respack", 64'(respack), 64'd0);
    chk("idle_wren", 64'(regWrEnOut), 64'd0);
    if (s.hold) begin
      tick();
      validIn = 1'b0;
      expRetired++;
      chk("held_wren", 64'(regWrEnOut), 64'd1);
      chk("held_idx", 64'(regWrIdxOut), 64'(s.hIdx));
      chk("held_data", regWrDataOut, s.hVal);
      chk("held_stall", 64'(wbStallOut), 64'd0);
      chkRetired("held_retired");
    end
    validIn = 1'b0;
  endtask

  nsVec_t nsTab[5];
  stVec_t stTab[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    validIn = 0; opcodeIn = 0; destRegIn = 0; destRegValidIn = 0; destRegValueIn = 0;
    isMemoryAccessDestIn = 0; memoryAddressDestIn = 0; storeDataIn = 0;
    reqack = 0; respcyc = 0;

    nsTab[0] = '{4'd3,  1'b1, 64'hDEAD,               1'b1};
    nsTab[1] = '{4'd5,  1'b0, 64'h1111,               1'b0};
    nsTab[2] = '{4'd15, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    nsTab[3] = '{4'd0,  1'b1, 64'h0,                  1'b1};
    nsTab[4] = '{4'd7,  1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};

    stTab[0] = '{64'h1000, 64'h55, 8'h89, 1'b0, 4'd0, 64'h0,    10'h389, 0, 0, 1'b0, 4'd0, 64'h0};
    stTab[1] = '{64'h2000, 64'hAA, 8'h23, 1'b1, 4'd4, 64'h8,    10'h323, 3, 2, 1'b0, 4'd0, 64'h0};
    stTab[2] = '{64'h3008, 64'h77, 8'hFF, 1'b1, 4'd2, 64'h1234, 10'h3FF, 1, 2, 1'b1, 4'd9, 64'h99};
    stTab[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 8'h00, 1'b0, 4'd0, 64'h0, 10'h300, 0, 3, 1'b1, 4'd1, 64'h5};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wren", 64'(regWrEnOut), 64'd0);
    chk("rst_reqcyc", 64'(reqcyc), 64'd0);
    chk("rst_respack", 64'(respack), 64'd0);
    chk("rst_stall", 64'(wbStallOut), 64'd0);
    chk("rst_req", req, 64'd0);
    chk("rst_reqtag", 64'(reqtag), 64'd0);
    chk("rst_reqdata", reqdata, 64'd0);
    chkRetired("rst_retired");
    reset = 1'b1;
    tick();

    reqack = 1'b1; respcyc = 1'b1;
    tick();
    chk("idle_ign_respack", 64'(respack), 64'd0);
    chk("idle_ign_stall", 64'(wbStallOut), 64'd0);
    chk("idle_ign_reqcyc", 64'(reqcyc), 64'd0);
    reqack = 1'b0; respcyc = 1'b0;

    foreach (nsTab[i]) nonStore(nsTab[i]);
    validIn = 1'b0;
    tick();
    chk("ns_drop_wren", 64'(regWrEnOut), 64'd0);

    foreach (stTab[i]) store(stTab[i]);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        nsVec_t v;
        v.idx   = 4'($urandom);
        v.dv    = 1'($urandom);
        v.val   = {$urandom, $urandom};
        v.expEn = v.dv;
        nonStore(v);
        if ($urandom_range(0, 2) == 0) begin
          validIn = 1'b0;
          tick();
          chk("rnd_gap_wren", 64'(regWrEnOut), 64'd0);
        end
      end else begin
        stVec_t s;
        s.addr    = {$urandom, $urandom};
        s.data    = {$urandom, $urandom};
        s.opc     = 8'($urandom);
        s.hasReg  = 1'($urandom);
        s.idx     = 4'($urandom);
        s.val     = {$urandom, $urandom};
        s.expTag  = 10'h300 + 10'(s.opc);
        s.ackDly  = $urandom_range(0, 3);
        s.respDly = $urandom_range(0, 3);
        s.hold    = 1'($urandom);
        s.hIdx    = 4'($urandom);
        s.hVal    = {$urandom, $urandom};
        store(s);
      end
    end
    validIn = 1'b0;
    tick();

    // reset while a store with a pending register write sits in REQ
    validIn = 1'b1; isMemoryAccessDestIn = 1'b1; memoryAddressDestIn = 64'h4000;
    storeDataIn = 64'h42; opcodeIn = 8'h11; destRegValidIn = 1'b1; destRegIn = 4'd6;
    destRegValueIn = 64'hBEEF;
    tick();
    validIn = 1'b0;
    chk("mid_reqcyc_before", 64'(reqcyc), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reqcyc", 64'(reqcyc), 64'd0);
    chk("mid_stall", 64'(wbStallOut), 64'd0);
    chk("mid_wren", 64'(regWrEnOut), 64'd0);
    chk("mid_respack", 64'(respack), 64'd0);
    expRetired = 0;
    chkRetired("mid_retired");
    reqack = 1'b1; respcyc = 1'b1;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_stall", 64'(wbStallOut), 64'd0);
      chk("post_rst_wren", 64'(regWrEnOut), 64'd0);
      chk("post_rst_reqcyc", 64'(reqcyc), 64'd0);
      chk("post_rst_respack", 64'(respack), 64'd0);
    end
    reqack = 1'b0; respcyc = 1'b0;

    nonStore('{4'd8, 1'b1, 64'hCAFE, 1'b1});
    validIn = 1'b0;
    tick();
    chkRetired("final_retired");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
